unary_belief_node: RTL and testbench

Parametrised unary node for the belief-propagation fabric. Holds N_STATES unary potentials of W bits each, loaded from an initialiser. Fuses each incoming factor message with the potentials (element-wise product, then max-normalisation back to W bits) and presents the resulting outward belief on a valid/ready port. Sits between the initialiser and the factor-function blocks, replacing the fixed two-state, load-on-reset unary register.

---
 rtl/unary_belief_node.sv | 132 +++++++++++++
 tb/tb_unary_belief_node.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_belief_node.sv
// Unary node for the belief-propagation fabric: fuses factor messages with stored
// unary potentials (element-wise product, max-normalised to W bits) behind valid/ready.
module unary_belief_node #(
  parameter int N_STATES = 2,
  parameter int W        = 8,
  parameter int ACCUM    = 0
) (
  input  logic                  CLK100MHZ,
  input  logic                  Reset,
  input  logic                  init_valid,
  input  logic [N_STATES*W-1:0] init_data,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [N_STATES*W-1:0] msg_data,
  output logic                  belief_valid,
  input  logic                  belief_ready,
  output logic [N_STATES*W-1:0] belief_data
);

  localparam int IW = (N_STATES > 1) ? $clog2(N_STATES) : 1;
  localparam int LW = $clog2(2 * W);
  localparam logic [IW-1:0] LAST = IW'(N_STATES - 1);
  localparam logic [W-1:0]  HALF = {1'b1, {(W-1){1'b0}}};
  localparam logic [LW-1:0] TOP  = LW'(W - 1);

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    pot   [N_STATES];
  logic [W-1:0]    msg_r [N_STATES];
  logic [2*W-1:0]  prod  [N_STATES];
  logic [2*W-1:0]  max_r;
  logic [IW-1:0]   idx;
  logic            idx_last;
  logic [2*W-1:0]  p_mul;
  logic [LW-1:0]   lead;
  logic [W-1:0]    norm_out;

  function automatic logic [LW-1:0] lead_one(input logic [2*W-1:0] v);
    logic [LW-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < 2 * W; i++)
      if (v[i]) l = LW'(i);
    return l;
  endfunction

  assign msg_ready = (state == IDLE);

  // Shift so the leading one of the running maximum lands on bit W-1.
  always_comb begin
    idx_last = (idx == LAST);
    p_mul    = (2*W)'(pot[idx]) * (2*W)'(msg_r[idx]);
    lead     = lead_one(max_r);
    if (max_r == '0)
      norm_out = HALF;
    else if (lead >= TOP)
      norm_out = W'(prod[idx] >> (lead - TOP));
    else
      norm_out = W'(prod[idx] << (TOP - lead));
  end

  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (init_valid)     state_nxt = DONE;
        else if (msg_valid) state_nxt = MULT;
      end
      MULT: if (idx_last) state_nxt = NORM;
      NORM: if (idx_last) state_nxt = DONE;
      DONE: if (belief_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N_STATES; i++) begin
        pot[i]   <= HALF;
        msg_r[i] <= '0;
        prod[i]  <= '0;
      end
      max_r        <= '0;
      idx          <= '0;
      belief_data  <= '0;
      belief_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (init_valid) begin
            for (int unsigned i = 0; i < N_STATES; i++)
              pot[i] <= init_data[i*W +: W];
            belief_data  <= init_data;
            belief_valid <= 1'b1;
          end else if (msg_valid) begin
            for (int unsigned i = 0; i < N_STATES; i++)
              msg_r[i] <= msg_data[i*W +: W];
            max_r <= '0;
            idx   <= '0;
          end
        end
        MULT: begin
          prod[idx] <= p_mul;
          if (p_mul > max_r) max_r <= p_mul;
          idx <= idx_last ? '0 : idx + 1'b1;
        end
        NORM: begin
          for (int unsigned i = 0; i < N_STATES; i++) begin
            if (idx == IW'(i)) begin
              belief_data[i*W +: W] <= norm_out;
              if (ACCUM != 0) pot[i] <= norm_out;
            end
          end
          if (idx_last) begin
            idx          <= '0;
            belief_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (belief_ready) belief_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_belief_node.sv
// Self-checking bench for unary_belief_node (N_STATES=2, W=8), ACCUM=0 and ACCUM=1 instances.
module tb_unary_belief_node;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_valid0 = 1'b0, msg_valid0 = 1'b0, belief_ready0 = 1'b0;
  logic [15:0] init_data0 = '0, msg_data0 = '0;
  logic        msg_ready0, belief_valid0;
  logic [15:0] belief_data0;
  logic        init_valid1 = 1'b0, msg_valid1 = 1'b0, belief_ready1 = 1'b0;
  logic [15:0] init_data1 = '0, msg_data1 = '0;
  logic        msg_ready1, belief_valid1;
  logic [15:0] belief_data1;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  always #5 clk = ~clk;

  unary_belief_node #(.N_STATES(2), .W(8), .ACCUM(0)) dut0 (
    .CLK100MHZ(clk), .Reset(rst),
    .init_valid(init_valid0), .init_data(init_data0),
    .msg_valid(msg_valid0), .msg_ready(msg_ready0), .msg_data(msg_data0),
    .belief_valid(belief_valid0), .belief_ready(belief_ready0), .belief_data(belief_data0)
  );

  unary_belief_node #(.N_STATES(2), .W(8), .ACCUM(1)) dut1 (
    .CLK100MHZ(clk), .Reset(rst),
    .init_valid(init_valid1), .init_data(init_data1),
    .msg_valid(msg_valid1), .msg_ready(msg_ready1), .msg_data(msg_data1),
    .belief_valid(belief_valid1), .belief_ready(belief_ready1), .belief_data(belief_data1)
  );

  // Element 0 listed first; it occupies the low byte of the bus.
  function automatic logic [15:0] pk(input logic [7:0] e0, input logic [7:0] e1);
    return {e1, e0};
  endfunction

  // Reference: scale products until the maximum lies in [128,255].
  function automatic logic [15:0] model(input logic [15:0] pot, input logic [15:0] m);
    int unsigned p0, p1, mx, r, l;
    logic [31:0] o0, o1;
    p0 = pot[7:0] * m[7:0];
    p1 = pot[15:8] * m[15:8];
    mx = (p0 > p1) ? p0 : p1;
    if (mx == 0) return 16'h8080;
    r = 0; l = 0;
    while (mx >= 256) begin mx = mx >> 1; r++; end
    while (mx < 128)  begin mx = mx << 1; l++; end
    o0 = (p0 >> r) << l;
    o1 = (p1 >> r) << l;
    return {o1[7:0], o0[7:0]};
  endfunction

  task automatic drive_init(input int sel, input logic [15:0] d);
    if (sel == 0) begin init_valid0 = 1'b1; init_data0 = d; end
    else          begin init_valid1 = 1'b1; init_data1 = d; end
    @(posedge clk); #1;
    init_valid0 = 1'b0; init_valid1 = 1'b0;
  endtask

  task automatic drive_msg(input int sel, input logic [15:0] m);
    if (sel == 0) begin msg_valid0 = 1'b1; msg_data0 = m; end
    else          begin msg_valid1 = 1'b1; msg_data1 = m; end
    @(posedge clk); #1;
    msg_valid0 = 1'b0; msg_valid1 = 1'b0;
  endtask

  // Counts edges from the last stimulus edge until belief_valid is seen; cyc=-1 on timeout.
  task automatic collect(input int sel, output logic [15:0] d, output int cyc);
    d = '0;
    cyc = 0;
    if ((sel == 0 ? belief_valid0 : belief_valid1) == 1'b1) begin
      d = (sel == 0) ? belief_data0 : belief_data1;
      return;
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if ((sel == 0 ? belief_valid0 : belief_valid1) == 1'b1) begin
        d = (sel == 0) ? belief_data0 : belief_data1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL timeout_dut%0d: belief_valid not seen after %0d cycles, required within 40", sel, cyc);
    cyc = -1;
  endtask

  task automatic ack(input int sel);
    if (sel == 0) belief_ready0 = 1'b1; else belief_ready1 = 1'b1;
    @(posedge clk); #1;
    belief_ready0 = 1'b0; belief_ready1 = 1'b0;
  endtask

  task automatic run_msg(input int sel, input logic [15:0] m, output logic [15:0] d, output int cyc);
    drive_msg(sel, m);
    collect(sel, d, cyc);
  endtask

  task automatic test_reset;
    logic [15:0] d, e;
    int cyc;
    #1 rst = 1'b1;
    #2;
    checks++; if (msg_ready0 !== 1'b1) begin errors++; $display("FAIL reset_msg_ready: got %b want 1", msg_ready0); end
    checks++; if (belief_valid0 !== 1'b0) begin errors++; $display("FAIL reset_belief_valid: got %b want 0", belief_valid0); end
    checks++; if (belief_data0 !== 16'h0000) begin errors++; $display("FAIL reset_belief_data: got %h want 0000", belief_data0); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (msg_ready0 !== 1'b1) begin errors++; $display("FAIL idle_msg_ready: got %b want 1", msg_ready0); end
    exp_q0.push_back(pk(8'h80, 8'h80));
    run_msg(0, pk(8'h01, 8'h01), d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL uniform_belief: got %h want %h", d, e); end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL msg_latency: got %0d want 4", cyc); end
    ack(0);
  endtask

  task automatic test_init_and_msg;
    logic [15:0] d, e;
    int cyc;
    exp_q0.push_back(pk(8'h80, 8'h40));
    drive_init(0, pk(8'h80, 8'h40));
    collect(0, d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL init_belief: got %h want %h", d, e); end
    checks++; if (cyc !== 0) begin errors++; $display("FAIL init_latency: valid not high one edge after init (extra %0d)", cyc); end
    ack(0);
    exp_q0.push_back(pk(8'h80, 8'h80));
    run_msg(0, pk(8'h40, 8'h80), d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL init_msg_belief: got %h want %h", d, e); end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL init_msg_latency: got %0d want 4", cyc); end
    ack(0);
  endtask

  task automatic test_shift;
    logic [15:0] d, e;
    logic [15:0] inits [2];
    logic [15:0] msgs  [2];
    logic [15:0] exps  [2];
    int cyc;
    inits[0] = pk(8'hFF, 8'h01); msgs[0] = pk(8'hFF, 8'h01); exps[0] = pk(8'hFE, 8'h00);
    inits[1] = pk(8'h01, 8'h02); msgs[1] = pk(8'h01, 8'h01); exps[1] = pk(8'h40, 8'h80);
    for (int k = 0; k < 2; k++) begin
      drive_init(0, inits[k]);
      ack(0);
      exp_q0.push_back(exps[k]);
      run_msg(0, msgs[k], d, cyc);
      e = exp_q0.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL shift_case%0d: got %h want %h", k, d, e); end
      ack(0);
    end
  endtask

  task automatic test_zero_msg;
    logic [15:0] d, e;
    int cyc;
    exp_q0.push_back(pk(8'h80, 8'h80));
    run_msg(0, 16'h0000, d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL zero_msg: got %h want %h", d, e); end
    ack(0);
  endtask

  task automatic test_backpressure;
    logic [15:0] d, e;
    int cyc;
    int bad;
    exp_q0.push_back(pk(8'hC0, 8'h80));
    run_msg(0, pk(8'h03, 8'h01), d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL bp_belief: got %h want %h", d, e); end
    bad = 0;
    init_valid0 = 1'b1; init_data0 = pk(8'h11, 8'h22);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (belief_valid0 !== 1'b1 || belief_data0 !== e || msg_ready0 !== 1'b0) bad++;
    end
    init_valid0 = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0 (data %h want %h)", bad, belief_data0, e); end
    ack(0);
    checks++; if (belief_valid0 !== 1'b0 || msg_ready0 !== 1'b1) begin errors++; $display("FAIL bp_release: valid %b ready %b want 0 1", belief_valid0, msg_ready0); end
    exp_q0.push_back(pk(8'h40, 8'h80));
    run_msg(0, pk(8'h01, 8'h01), d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL bp_init_ignored: got %h want %h", d, e); end
    ack(0);
  endtask

  task automatic test_priority;
    logic [15:0] d, e;
    int cyc;
    exp_q0.push_back(pk(8'h20, 8'h10));
    init_valid0 = 1'b1; init_data0 = pk(8'h20, 8'h10);
    msg_valid0  = 1'b1; msg_data0  = pk(8'hFF, 8'hFF);
    @(posedge clk); #1;
    init_valid0 = 1'b0; msg_valid0 = 1'b0;
    collect(0, d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e || cyc !== 0) begin errors++; $display("FAIL prio_init: got %h after %0d extra want %h after 0", d, cyc, e); end
    ack(0);
    checks++; if (msg_ready0 !== 1'b1) begin errors++; $display("FAIL prio_idle: msg_ready %b want 1", msg_ready0); end
    exp_q0.push_back(pk(8'h80, 8'h40));
    run_msg(0, pk(8'h01, 8'h01), d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL prio_pot: got %h want %h", d, e); end
    ack(0);
  endtask

  task automatic test_accum;
    logic [15:0] d, e;
    int cyc;
    drive_init(1, pk(8'h01, 8'h02));
    ack(1);
    for (int k = 0; k < 2; k++) begin
      exp_q1.push_back(pk(8'h40, 8'h80));
      run_msg(1, pk(8'h01, 8'h01), d, cyc);
      e = exp_q1.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL accum_msg%0d: got %h want %h", k, d, e); end
      ack(1);
    end
    drive_init(1, pk(8'hFF, 8'h01));
    ack(1);
    exp_q1.push_back(pk(8'hFE, 8'h00));
    exp_q1.push_back(pk(8'hFE, 8'h00));
    run_msg(1, pk(8'hFF, 8'h01), d, cyc);
    e = exp_q1.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL accum_trunc: got %h want %h", d, e); end
    ack(1);
    run_msg(1, pk(8'h01, 8'h01), d, cyc);
    e = exp_q1.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL accum_writeback: got %h want %h", d, e); end
    ack(1);
  endtask

  task automatic test_random;
    logic [15:0] d, e, pot, m;
    int cyc;
    pot = 16'($urandom_range(0, 65535));
    exp_q0.push_back(pot);
    drive_init(0, pot);
    collect(0, d, cyc);
    e = exp_q0.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rand_init: got %h want %h", d, e); end
    ack(0);
    for (int k = 0; k < 6; k++) begin
      m = 16'($urandom_range(0, 65535));
      if (k == 0) m[7:0] = 8'h00;
      exp_q0.push_back(model(pot, m));
      run_msg(0, m, d, cyc);
      e = exp_q0.pop_front();
      checks++; if (d !== e || cyc !== 4) begin errors++; $display("FAIL rand_msg%0d: pot %h msg %h got %h (lat %0d) want %h (lat 4)", k, pot, m, d, cyc, e); end
      ack(0);
    end
  endtask

  task automatic test_reset_mid_norm;
    logic [15:0] d, e;
    int cyc;
    drive_msg(0, pk(8'h37, 8'h05));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (belief_valid0 !== 1'b0 || belief_data0 !== 16'h0000) begin errors++; $display("FAIL async_reset: valid %b data %h want 0 0000", belief_valid0, belief_data0); end
    checks++; if (msg_ready0 !== 1'b1 || belief_data1 !== 16'h0000) begin errors++; $display("FAIL async_reset_idle: ready %b data1 %h want 1 0000", msg_ready0, belief_data1); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (belief_valid0 !== 1'b0) begin errors++; $display("FAIL no_partial_belief: valid %b want 0", belief_valid0); end
    for (int sel = 0; sel < 2; sel++) begin
      if (sel == 0) exp_q0.push_back(pk(8'h80, 8'h80));
      else          exp_q1.push_back(pk(8'h80, 8'h80));
      run_msg(sel, pk(8'h01, 8'h01), d, cyc);
      e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL post_reset_dut%0d: got %h want %h", sel, d, e); end
      ack(sel);
    end
  endtask

  initial begin
    test_reset;
    test_init_and_msg;
    test_shift;
    test_zero_msg;
    test_backpressure;
    test_priority;
    test_accum;
    test_random;
    test_reset_mid_norm;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
